// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised RGB-LCD timing generator in the pixel-clock domain.
// It generates HSYNC/VSYNC/DE from a pair of raster counters and pulls RGB565
// pixels from the display FIFO, expanding them to RGB888. It supports a graceful
// start and stop, fills underflowed pixels with a fixed colour and counts them,
// and issues a FIFO flush pulse once per frame.
//
// Pipeline: stage 0 is the counter state (FIFO_RE is decoded here), stage 1 is
// the cycle in which FIFO_DATA is valid, and stage 2 holds the registered LCD
// outputs. Every LCD-side output therefore trails its counter state by 2 cycles.
//
// FIFO read handshake: FIFO_RE is asserted for one cycle per pixel, and only
// while FIFO_EMPTY is low in that same cycle. The FIFO must present the word on
// FIFO_DATA in the following cycle. A pixel whose read is refused because the
// FIFO is empty is never retried; the fill colour is shown in its place.
module lcd_timing_gen #(
    parameter int          H_ACTIVE  = 480,
    parameter int          H_FP      = 8,
    parameter int          H_SYNC    = 4,
    parameter int          H_BP      = 43,
    parameter int          V_ACTIVE  = 272,
    parameter int          V_FP      = 8,
    parameter int          V_SYNC    = 4,
    parameter int          V_BP      = 12,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter bit          DE_POL    = 1'b1,
    parameter bit          FLUSH_EN  = 1'b1,
    parameter int          FLUSH_LEN = 4,
    parameter logic [15:0] UF_COLOR  = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [15:0] FIFO_DATA,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RE,
    output logic        FIFO_RST,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic        LCD_DE,
    output logic [7:0]  LCD_R,
    output logic [7:0]  LCD_G,
    output logic [7:0]  LCD_B,
    output logic        FRAME_START,
    output logic [15:0] UF_COUNT,
    output logic [1:0]  state_dbg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] HC_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_START  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VC_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] VC_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_START  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    // One extra bit so FLUSH_LEN == H_TOTAL still fits when H_TOTAL is a power of two.
    localparam logic [HC_W:0]   FLUSH_CNT = (HC_W + 1)'(FLUSH_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t          state;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;

    logic running;
    logic h_last;
    logic v_last;
    logic frame_wrap;

    logic s0_act;
    logic s0_uf;
    logic s0_hs;
    logic s0_vs;
    logic s0_fs;

    logic s1_act;
    logic s1_uf;
    logic s1_hs;
    logic s1_vs;
    logic s1_fs;

    logic [15:0] pix_word;
    logic [15:0] uf_acc;

    assign state_dbg  = state;
    assign running    = (state != IDLE);
    assign h_last     = (hc == HC_LAST);
    assign v_last     = (vc == VC_LAST);
    assign frame_wrap = running && h_last && v_last;

    // Stage 0: decode the current counter state.
    assign s0_act   = running && (hc < HC_ACT) && (vc < VC_ACT);
    assign s0_uf    = s0_act && FIFO_EMPTY;
    assign s0_hs    = running && (hc >= HS_START) && (hc < HS_END);
    assign s0_vs    = running && (vc >= VS_START) && (vc < VS_END);
    assign s0_fs    = running && (hc == '0) && (vc == '0);
    assign FIFO_RE  = s0_act && !FIFO_EMPTY;
    // The flush window sits on the first sync line, which is never an active line.
    assign FIFO_RST = FLUSH_EN && running && (vc == VS_START) && ({1'b0, hc} < FLUSH_CNT);

    // Stage 1: the FIFO word arrives now unless this pixel underflowed.
    assign pix_word = s1_uf ? UF_COLOR : FIFO_DATA;

    // Run/stop state machine together with the raster counters it gates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            hc    <= '0;
            vc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hc <= '0;
                    vc <= '0;
                    if (ENABLE) state <= RUN;
                end
                RUN, STOPPING: begin
                    if (h_last) begin
                        hc <= '0;
                        vc <= v_last ? '0 : vc + 1'b1;
                    end else begin
                        hc <= hc + 1'b1;
                    end
                    if (state == RUN) begin
                        if (!ENABLE) state <= STOPPING;
                    end else if (h_last && v_last) begin
                        state <= ENABLE ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 -> stage 1: carry the pixel attributes alongside the FIFO latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_act <= 1'b0;
            s1_uf  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_fs  <= 1'b0;
        end else begin
            s1_act <= s0_act;
            s1_uf  <= s0_uf;
            s1_hs  <= s0_hs;
            s1_vs  <= s0_vs;
            s1_fs  <= s0_fs;
        end
    end

    // Stage 2: registered LCD outputs with polarity applied and RGB565 -> RGB888 expansion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LCD_HSYNC   <= ~HS_POL;
            LCD_VSYNC   <= ~VS_POL;
            LCD_DE      <= ~DE_POL;
            LCD_R       <= 8'h00;
            LCD_G       <= 8'h00;
            LCD_B       <= 8'h00;
            FRAME_START <= 1'b0;
        end else begin
            LCD_HSYNC   <= s1_hs  ? HS_POL : ~HS_POL;
            LCD_VSYNC   <= s1_vs  ? VS_POL : ~VS_POL;
            LCD_DE      <= s1_act ? DE_POL : ~DE_POL;
            LCD_R       <= s1_act ? {pix_word[15:11], pix_word[15:13]} : 8'h00;
            LCD_G       <= s1_act ? {pix_word[10:5],  pix_word[10:9]}  : 8'h00;
            LCD_B       <= s1_act ? {pix_word[4:0],   pix_word[4:2]}   : 8'h00;
            FRAME_START <= s1_fs;
        end
    end

    // Underflow tally per frame; published and cleared on the frame wrap cycle.
    // The wrap cycle is in the back porch, so no underflow can be lost there.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            uf_acc   <= 16'h0000;
            UF_COUNT <= 16'h0000;
        end else if (frame_wrap) begin
            UF_COUNT <= uf_acc;
            uf_acc   <= 16'h0000;
        end else if (s0_uf && (uf_acc != 16'hFFFF)) begin
            uf_acc <= uf_acc + 16'h0001;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed bench for lcd_timing_gen with a tiny raster
// (H 4/1/1/1 -> 7 clocks per line, V 3/1/1/1 -> 6 lines, 42 clocks per frame).
// Counter index k counts clocks from the first RUN cycle of a run; the pixel
// shown on the LCD pins at that moment belongs to index o = k - 2.
module tb_lcd_timing_gen;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        enable     = 1'b0;
    logic        fifo_empty = 1'b0;
    logic [15:0] fifo_data  = 16'h0000;

    logic        fifo_re,   fifo_re_p;
    logic        fifo_rst,  fifo_rst_p;
    logic        hsync,     hsync_p;
    logic        vsync,     vsync_p;
    logic        de,        de_p;
    logic [7:0]  lcd_r,     lcd_r_p;
    logic [7:0]  lcd_g,     lcd_g_p;
    logic [7:0]  lcd_b,     lcd_b_p;
    logic        frame_start, frame_start_p;
    logic [15:0] uf_count,  uf_count_p;
    logic [1:0]  state_dbg, state_dbg_p;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];
    logic [15:0] src_tab [8] = '{16'hF800, 16'h07E0, 16'h8410, 16'h1234,
                                 16'hFFFF, 16'h0000, 16'hA5A5, 16'h0841};
    int   rd_idx = 0;
    int   run_id = 0;
    logic re_pre = 1'b0;

    // Clock
    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
        .FLUSH_EN(1'b1), .FLUSH_LEN(4), .UF_COLOR(16'h001F)
    ) dut (
        .CLK(clk), .RST(rst), .ENABLE(enable),
        .FIFO_DATA(fifo_data), .FIFO_EMPTY(fifo_empty),
        .FIFO_RE(fifo_re), .FIFO_RST(fifo_rst),
        .LCD_HSYNC(hsync), .LCD_VSYNC(vsync), .LCD_DE(de),
        .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b),
        .FRAME_START(frame_start), .UF_COUNT(uf_count),
        .state_dbg(state_dbg)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DE_POL(1'b1),
        .FLUSH_EN(1'b1), .FLUSH_LEN(4), .UF_COLOR(16'h001F)
    ) dut_p (
        .CLK(clk), .RST(rst), .ENABLE(enable),
        .FIFO_DATA(fifo_data), .FIFO_EMPTY(fifo_empty),
        .FIFO_RE(fifo_re_p), .FIFO_RST(fifo_rst_p),
        .LCD_HSYNC(hsync_p), .LCD_VSYNC(vsync_p), .LCD_DE(de_p),
        .LCD_R(lcd_r_p), .LCD_G(lcd_g_p), .LCD_B(lcd_b_p),
        .FRAME_START(frame_start_p), .UF_COUNT(uf_count_p),
        .state_dbg(state_dbg_p)
    );

    function automatic logic [23:0] expand(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    function automatic bit active(input int x);
        return (x >= 0) && ((x % 7) < 4) && (((x / 7) % 6) < 3);
    endfunction

    function automatic bit hs_on(input int x);
        return (x >= 0) && ((x % 7) == 5);
    endfunction

    function automatic bit vs_on(input int x);
        return (x >= 0) && (((x / 7) % 6) == 4);
    endfunction

    function automatic bit flush_on(input int x);
        return (x >= 0) && (((x / 7) % 6) == 4) && ((x % 7) < 4);
    endfunction

    // FIFO held empty over counter states 84..91 (5 active pixels) and 168..169 (2 pixels) of run 1.
    function automatic bit is_empty(input int x);
        return (run_id == 1) && (((x >= 84) && (x < 92)) || ((x >= 168) && (x < 170)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Read port of the display FIFO: the word follows FIFO_RE by one cycle.
    always begin
        @(negedge clk);
        #4;
        re_pre = fifo_re;
    end

    always @(posedge clk) begin
        if (re_pre) begin
            fifo_data <= src_tab[rd_idx];
            exp_q.push_back(expand(src_tab[rd_idx]));
            rd_idx    <= (rd_idx + 1) % 8;
        end
    end

    task automatic check_reset_values(input logic [15:0] uf);
        check("rst_hsync", hsync, 1'b1);
        check("rst_vsync", vsync, 1'b1);
        check("rst_de", de, 1'b0);
        check("rst_rgb", {lcd_r, lcd_g, lcd_b}, 24'h0);
        check("rst_fifo_re", fifo_re, 1'b0);
        check("rst_fifo_rst", fifo_rst, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_uf_count", uf_count, uf);
        check("rst_state", state_dbg, 2'd0);
        check("rst_hsync_pol1", hsync_p, 1'b0);
        check("rst_vsync_pol1", vsync_p, 1'b0);
        check("rst_de_pol1", de_p, 1'b0);
    endtask

    // One clock: drive inputs after the falling edge, then compare against index k / o.
    task automatic tick(input int k, input int o, input bit en, input logic [15:0] uf);
        logic [23:0] exp_rgb;
        @(negedge clk);
        enable     = en;
        fifo_empty = is_empty(k);
        #1;
        check("fifo_re", fifo_re, active(k) && !is_empty(k));
        check("fifo_re_pol1", fifo_re_p, active(k) && !is_empty(k));
        check("fifo_rst", fifo_rst, flush_on(k));
        check("fifo_rst_pol1", fifo_rst_p, flush_on(k));
        check("de", de, active(o));
        check("de_pol1", de_p, active(o));
        check("hsync", hsync, !hs_on(o));
        check("vsync", vsync, !vs_on(o));
        check("hsync_pol1", hsync_p, hs_on(o));
        check("vsync_pol1", vsync_p, vs_on(o));
        check("frame_start", frame_start, (o >= 0) && ((o % 42) == 0));
        check("frame_start_pol1", frame_start_p, (o >= 0) && ((o % 42) == 0));
        check("uf_count", uf_count, uf);
        check("uf_count_pol1", uf_count_p, uf);
        exp_rgb = 24'h0;
        if (active(o)) begin
            if (is_empty(o)) exp_rgb = 24'h0000FF;
            else if (exp_q.size() > 0) exp_rgb = exp_q.pop_front();
            else check("sb_depth", exp_q.size(), 1);
        end
        check("rgb", {lcd_r, lcd_g, lcd_b}, exp_rgb);
        check("rgb_pol1", {lcd_r_p, lcd_g_p, lcd_b_p}, exp_rgb);
        if (run_id == 1 && o == 0) check("rgb_f800", {lcd_r, lcd_g, lcd_b}, 24'hFF0000);
        if (run_id == 1 && o == 1) check("rgb_07e0", {lcd_r, lcd_g, lcd_b}, 24'h00FF00);
        if (run_id == 1 && o == 2) check("rgb_8410", {lcd_r, lcd_g, lcd_b}, 24'h848284);
    endtask

    initial begin
        // Reset held over the first edge, then released while disabled.
        @(negedge clk);
        #1;
        check_reset_values(16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(-1, -1, 1'b0, 16'h0000);

        // Run 1: five frames, underflow in frames 2 and 4, ENABLE dropped mid frame 4.
        run_id = 1;
        tick(-1, -1, 1'b1, 16'h0000);
        for (int j = 0; j < 210; j++) begin
            tick(j, (j >= 2) ? j - 2 : -1, (j < 180),
                 (j < 126) ? 16'd0 : (j < 168) ? 16'd5 : 16'd0);
            if (j == 100) begin
                check("state_run", state_dbg, 2'd1);
                check("state_run_pol1", state_dbg_p, 2'd1);
            end
            if (j == 181) check("state_stopping", state_dbg, 2'd2);
        end

        // Pipeline drains, then IDLE with sync inactive and UF_COUNT held.
        for (int j = 210; j < 230; j++) begin
            tick(-1, (j - 2 <= 209) ? j - 2 : -1, 1'b0, 16'd2);
            if (j == 215) check("state_idle", state_dbg, 2'd0);
        end
        tick(-1, -1, 1'b1, 16'd2);

        // Run 2: restart from (0,0), then reset in the middle of an active line.
        run_id = 2;
        for (int k = 0; k <= 10; k++) tick(k, (k >= 2) ? k - 2 : -1, 1'b1, 16'd2);
        check("pre_rst_de", de, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values(16'h0000);
        exp_q.delete();
        @(negedge clk);
        #1;
        check_reset_values(16'h0000);
        rst = 1'b0;

        // Run 3: ENABLE already high, so the first counter state follows release by one edge.
        run_id = 3;
        for (int k = 0; k < 46; k++) tick(k, (k >= 2) ? k - 2 : -1, 1'b1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
